stage_id: RTL and testbench
===========================

STAGE_ID -- requirements
Module: stage_id

Interface
REQ-001 clock  in  1  sole clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-003 if_pc, if_inst, if_valid  in  32,32,1  PC, instruction word and valid flag from fetch.
REQ-004 flush  in  1  branch taken in EX/MEM; squash younger instructions.
REQ-005 ex_memread, ex_rd  in  1,5  instruction now in EX is a load; its destination register.
REQ-006 wb_we, wb_rd, wb_data  in  1,5,32  register-file write port from write-back.
REQ-007 stall  out  1  combinational; when 1, fetch holds its PC.
REQ-008 id_valid, id_pc  out  1,32  ID/EX valid flag and PC.
REQ-009 id_rs_data, id_rt_data, id_imm  out  32 each  operands and extended immediate.
REQ-010 id_rs, id_rt, id_rd  out  5 each  register numbers.
REQ-011 id_opcode, id_funct  out  6 each  inst[31:26], inst[5:0].

Function
REQ-012 IF/ID latch (pc, inst, valid) SHALL update per edge with priority: reset > flush > stall > load.
- flush: valid=0, inst=0.
- stall: hold.
- otherwise: capture if_*.
REQ-013 ID/EX outputs SHALL be registered, loaded from decode of the IF/ID contents, with priority: reset > flush > stall > load.
- flush and stall both load a bubble: id_valid=0, all other outputs 0.
- Latency: an instruction accepted at edge N appears on id_* after edge N+1.
REQ-014 Decode: id_rs=inst[25:21], id_rt=inst[20:16].
- id_rd=inst[15:11] when opcode==0, else inst[20:16].
REQ-015 Immediate: id_imm = zero-extended inst[15:0] for opcodes 0x0C, 0x0D, 0x0E; sign-extended inst[15:0] for all other opcodes.
REQ-016 stall SHALL be 1 iff all of the following hold:
- IF/ID valid,
- ex_memread,
- ex_rd!=0,
- ex_rd equals inst[25:21] or inst[20:16].
REQ-017 stall SHALL be 0 while reset or flush is 1.
- When flush and a stall condition coincide, flush wins.
REQ-018 Register file: 32 x 32 bits; register 0 reads 0 always.
- Write occurs at the edge when wb_we==1 and wb_rd!=0.
- Writes to register 0 are discarded.
REQ-019 Read ports are combinational on the IF/ID rs/rt fields; ID/EX captures the read value.
REQ-020 A stall lasts exactly one cycle per load-use pair.
- The next cycle, EX holds the bubble, ex_memread=0 and stall releases.

Reset
REQ-021 Reset SHALL clear:
- IF/ID: valid=0, pc=0, inst=0.
- All ID/EX outputs to 0.
- All 32 registers to 0.
REQ-022 Reset asserted mid-stall or mid-flush SHALL override both; the first edge after deassertion loads if_* normally.

Configuration
REQ-023 Macro ID_WB_BYPASS_EN.
- Defined: a read of register r!=0 in the same cycle as a write to r (wb_we=1, wb_rd=r) SHALL return wb_data.
- Undefined: such a read SHALL return the pre-write value.
- All other behaviour is identical in both builds.

Verification
REQ-024 Bench SHALL cover:
- Reset, then feed if_inst=0x2008FFFF (addi $8,$0,-1), if_valid=1 -> two edges later id_valid=1, id_rt=8, id_rd=8, id_imm=0xFFFFFFFF.
- Feed 0x3508FFFF (ori) -> id_imm=0x0000FFFF. Feed R-type 0x01095020 -> id_rd=10, id_funct=0x20.
- ex_memread=1, ex_rd=9, IF/ID holds an instruction with rs=9 -> stall=1 for one cycle, bubble at id_*, IF/ID unchanged; with ex_rd=0 -> stall=0.
- Stall condition plus flush=1 in the same cycle -> stall=0, IF/ID and ID/EX both bubbles.
- wb_we=1, wb_rd=5, wb_data=0xDEADBEEF while decoding rs=5 -> id_rs_data=0xDEADBEEF with macro defined, old value (0 after reset) without it.
- wb_we=1, wb_rd=0, wb_data=0x12345678, then read rs=0 -> id_rs_data=0; reset asserted during a stall -> all outputs 0 next edge.

Source files
------------

// File: rtl/stage_id.sv
// Instruction-decode stage: IF/ID latch, 32x32 register file, load-use hazard detection and ID/EX register.
// Define ID_WB_BYPASS_EN to forward a same-cycle write-back value to the register-file read ports.
module stage_id (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_inst_i,
    input  logic        if_valid_i,
    input  logic        flush_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        stall_o,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_rs_data_o,
    output logic [31:0] id_rt_data_o,
    output logic [31:0] id_imm_o,
    output logic [4:0]  id_rs_o,
    output logic [4:0]  id_rt_o,
    output logic [4:0]  id_rd_o,
    output logic [5:0]  id_opcode_o,
    output logic [5:0]  id_funct_o
);

    // IF/ID latch
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d;

    // ID/EX register
    logic        idex_valid_q, idex_valid_d;
    logic [31:0] idex_pc_q, idex_pc_d;
    logic [31:0] idex_rs_data_q, idex_rs_data_d;
    logic [31:0] idex_rt_data_q, idex_rt_data_d;
    logic [31:0] idex_imm_q, idex_imm_d;
    logic [4:0]  idex_rs_q, idex_rs_d;
    logic [4:0]  idex_rt_q, idex_rt_d;
    logic [4:0]  idex_rd_q, idex_rd_d;
    logic [5:0]  idex_opcode_q, idex_opcode_d;
    logic [5:0]  idex_funct_q, idex_funct_d;

    logic [31:0] regs_q [0:31];

    logic [5:0]  dec_opcode;
    logic [5:0]  dec_funct;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        load_use;

    assign dec_opcode = ifid_inst_q[31:26];
    assign dec_funct  = ifid_inst_q[5:0];
    assign dec_rs     = ifid_inst_q[25:21];
    assign dec_rt     = ifid_inst_q[20:16];

    always_comb begin
        dec_rd  = dec_rt;
        dec_imm = {{16{ifid_inst_q[15]}}, ifid_inst_q[15:0]};
        if (dec_opcode == 6'h00) begin
            dec_rd = ifid_inst_q[15:11];
        end
        // andi / ori / xori take a zero-extended immediate
        if (dec_opcode == 6'h0C || dec_opcode == 6'h0D || dec_opcode == 6'h0E) begin
            dec_imm = {16'h0000, ifid_inst_q[15:0]};
        end
    end

    // Load in EX whose destination is a source of the instruction in ID.
    assign load_use = ifid_valid_q && ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == dec_rs) || (ex_rd_i == dec_rt));
    assign stall_o  = load_use && !flush_i && !reset_i;

    // Register file: one register per generate instance; register 0 is never written.
    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                regs_q[gi] <= 32'h0;
            end else if (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == 5'(gi))) begin
                regs_q[gi] <= wb_data_i;
            end
        end
    end

    always_comb begin
        rs_data = (dec_rs == 5'd0) ? 32'h0 : regs_q[dec_rs];
        rt_data = (dec_rt == 5'd0) ? 32'h0 : regs_q[dec_rt];
`ifdef ID_WB_BYPASS_EN
        if (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == dec_rs)) begin
            rs_data = wb_data_i;
        end
        if (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == dec_rt)) begin
            rt_data = wb_data_i;
        end
`endif
    end

    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;
        if (flush_i) begin
            ifid_pc_d    = 32'h0;
            ifid_inst_d  = 32'h0;
            ifid_valid_d = 1'b0;
        end else if (!stall_o) begin
            ifid_pc_d    = if_pc_i;
            ifid_inst_d  = if_inst_i;
            ifid_valid_d = if_valid_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ifid_pc_q    <= 32'h0;
            ifid_inst_q  <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Flush and stall both send an all-zero bubble into EX.
    always_comb begin
        idex_valid_d   = 1'b0;
        idex_pc_d      = 32'h0;
        idex_rs_data_d = 32'h0;
        idex_rt_data_d = 32'h0;
        idex_imm_d     = 32'h0;
        idex_rs_d      = 5'd0;
        idex_rt_d      = 5'd0;
        idex_rd_d      = 5'd0;
        idex_opcode_d  = 6'd0;
        idex_funct_d   = 6'd0;
        if (!flush_i && !stall_o) begin
            idex_valid_d   = ifid_valid_q;
            idex_pc_d      = ifid_pc_q;
            idex_rs_data_d = rs_data;
            idex_rt_data_d = rt_data;
            idex_imm_d     = dec_imm;
            idex_rs_d      = dec_rs;
            idex_rt_d      = dec_rt;
            idex_rd_d      = dec_rd;
            idex_opcode_d  = dec_opcode;
            idex_funct_d   = dec_funct;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            idex_valid_q   <= 1'b0;
            idex_pc_q      <= 32'h0;
            idex_rs_data_q <= 32'h0;
            idex_rt_data_q <= 32'h0;
            idex_imm_q     <= 32'h0;
            idex_rs_q      <= 5'd0;
            idex_rt_q      <= 5'd0;
            idex_rd_q      <= 5'd0;
            idex_opcode_q  <= 6'd0;
            idex_funct_q   <= 6'd0;
        end else begin
            idex_valid_q   <= idex_valid_d;
            idex_pc_q      <= idex_pc_d;
            idex_rs_data_q <= idex_rs_data_d;
            idex_rt_data_q <= idex_rt_data_d;
            idex_imm_q     <= idex_imm_d;
            idex_rs_q      <= idex_rs_d;
            idex_rt_q      <= idex_rt_d;
            idex_rd_q      <= idex_rd_d;
            idex_opcode_q  <= idex_opcode_d;
            idex_funct_q   <= idex_funct_d;
        end
    end

    assign id_valid_o   = idex_valid_q;
    assign id_pc_o      = idex_pc_q;
    assign id_rs_data_o = idex_rs_data_q;
    assign id_rt_data_o = idex_rt_data_q;
    assign id_imm_o     = idex_imm_q;
    assign id_rs_o      = idex_rs_q;
    assign id_rt_o      = idex_rt_q;
    assign id_rd_o      = idex_rd_q;
    assign id_opcode_o  = idex_opcode_q;
    assign id_funct_o   = idex_funct_q;

endmodule

// File: tb/tb_stage_id.sv
// Scoreboard bench for stage_id: stimulus pushes expected ID/EX records, a negedge monitor pops and compares.
module tb_stage_id;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc, if_inst;
    logic        if_valid, flush, ex_memread, wb_we;
    logic [4:0]  ex_rd, wb_rd;
    logic [31:0] wb_data;
    logic        stall, id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_opcode, id_funct;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  opcode;
        logic [5:0]  funct;
    } rec_t;

    rec_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    stage_id dut (
        .clock_i(clk), .reset_i(reset),
        .if_pc_i(if_pc), .if_inst_i(if_inst), .if_valid_i(if_valid),
        .flush_i(flush), .ex_memread_i(ex_memread), .ex_rd_i(ex_rd),
        .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .stall_o(stall), .id_valid_o(id_valid), .id_pc_o(id_pc),
        .id_rs_data_o(id_rs_data), .id_rt_data_o(id_rt_data), .id_imm_o(id_imm),
        .id_rs_o(id_rs), .id_rt_o(id_rt), .id_rd_o(id_rd),
        .id_opcode_o(id_opcode), .id_funct_o(id_funct)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic feed(input logic [31:0] pc, input logic [31:0] inst);
        if_pc    = pc;
        if_inst  = inst;
        if_valid = 1'b1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] op, input logic [5:0] fn);
        rec_t r;
        r = '{pc: pc, rs_data: rsd, rt_data: rtd, imm: imm, rs: rs, rt: rt, rd: rd, opcode: op, funct: fn};
        exp_q.push_back(r);
    endtask

    // Monitor: every valid ID/EX record must match the oldest expected one.
    always @(negedge clk) begin
        rec_t act, e;
        if (id_valid === 1'b1) begin
            act = '{pc: id_pc, rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
                    rs: id_rs, rt: id_rt, rd: id_rd, opcode: id_opcode, funct: id_funct};
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_output: got pc=%h with no expected record", id_pc);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    mismatched++;
                    $display("FAIL idex_record: got pc=%h rsd=%h rtd=%h imm=%h rs=%0d rt=%0d rd=%0d op=%h fn=%h expected pc=%h rsd=%h rtd=%h imm=%h rs=%0d rt=%0d rd=%0d op=%h fn=%h",
                             act.pc, act.rs_data, act.rt_data, act.imm, act.rs, act.rt, act.rd, act.opcode, act.funct,
                             e.pc, e.rs_data, e.rt_data, e.imm, e.rs, e.rt, e.rd, e.opcode, e.funct);
                end else begin
                    $display("txn pc=%h rsd=%h rtd=%h imm=%h rd=%0d ok", act.pc, act.rs_data, act.rt_data, act.imm, act.rd);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; if_pc = 32'h0; if_inst = 32'h0; if_valid = 1'b0; flush = 1'b0;
        ex_memread = 1'b0; ex_rd = 5'd0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        cyc(); cyc();
        chk("reset_id_valid", {31'h0, id_valid}, 32'h0);
        chk("reset_id_pc", id_pc, 32'h0);
        chk("reset_id_rs_data", id_rs_data, 32'h0);
        chk("reset_id_imm", id_imm, 32'h0);
        chk("reset_stall", {31'h0, stall}, 32'h0);

        // Preload registers; write to r0 must be discarded.
        reset = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'hA5A5A5A5; cyc();
        wb_rd = 5'd9; wb_data = 32'h00001234; cyc();
        wb_rd = 5'd0; wb_data = 32'h12345678; cyc();
        wb_we = 1'b0;

        feed(32'h100, 32'h2008FFFF);
        push(32'h100, 32'h0, 32'hA5A5A5A5, 32'hFFFFFFFF, 5'd0, 5'd8, 5'd8, 6'h08, 6'h3F);
        cyc();
        feed(32'h104, 32'h3508FFFF);
        push(32'h104, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0000FFFF, 5'd8, 5'd8, 5'd8, 6'h0D, 6'h3F);
        cyc();
        feed(32'h108, 32'h01095020);
        push(32'h108, 32'hA5A5A5A5, 32'h00001234, 32'h00005020, 5'd8, 5'd9, 5'd10, 6'h00, 6'h20);
        cyc();
        feed(32'h10C, 32'h01205020);
        push(32'h10C, 32'h00001234, 32'h0, 32'h00005020, 5'd9, 5'd0, 5'd10, 6'h00, 6'h20);
        cyc();

        // Load-use on rs=9: one stall cycle, bubble into EX, IF/ID held.
        feed(32'h110, 32'h200A0005);
        push(32'h110, 32'h0, 32'h0, 32'h00000005, 5'd0, 5'd10, 5'd10, 6'h08, 6'h05);
        ex_memread = 1'b1; ex_rd = 5'd9;
        #1 chk("stall_load_use", {31'h0, stall}, 32'h1);
        cyc();
        chk("stall_bubble_valid", {31'h0, id_valid}, 32'h0);
        ex_memread = 1'b0;
        #1 chk("stall_released", {31'h0, stall}, 32'h0);
        cyc();

        // ex_rd=0 never stalls even though it matches rs=0.
        feed(32'h114, 32'h01205020);
        ex_memread = 1'b1; ex_rd = 5'd0;
        #1 chk("stall_ex_rd_zero", {31'h0, stall}, 32'h0);
        cyc();

        // Hazard coinciding with flush: flush wins, both latches bubble.
        feed(32'h118, 32'h2008FFFF);
        ex_rd = 5'd9; flush = 1'b1;
        #1 chk("stall_flush_wins", {31'h0, stall}, 32'h0);
        cyc();
        chk("flush_idex_valid", {31'h0, id_valid}, 32'h0);
        chk("flush_idex_pc", id_pc, 32'h0);
        chk("flush_idex_rs", {27'h0, id_rs}, 32'h0);
        flush = 1'b0; ex_memread = 1'b0; if_valid = 1'b0;
        cyc();
        chk("flush_ifid_valid", {31'h0, id_valid}, 32'h0);
        chk("flush_ifid_pc", id_pc, 32'h0);
        chk("flush_ifid_imm", id_imm, 32'h0);
        chk("flush_ifid_rs", {27'h0, id_rs}, 32'h0);

        // Same-cycle write-back to the register being read.
        feed(32'h200, 32'h00A05820);
`ifdef ID_WB_BYPASS_EN
        push(32'h200, 32'hDEADBEEF, 32'h0, 32'h00005820, 5'd5, 5'd0, 5'd11, 6'h00, 6'h20);
`else
        push(32'h200, 32'h0, 32'h0, 32'h00005820, 5'd5, 5'd0, 5'd11, 6'h00, 6'h20);
`endif
        cyc();
        if_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        cyc();
        wb_we = 1'b0;
        feed(32'h204, 32'h00A05820);
        push(32'h204, 32'hDEADBEEF, 32'h0, 32'h00005820, 5'd5, 5'd0, 5'd11, 6'h00, 6'h20);
        cyc();
        if_valid = 1'b0;
        cyc();

        // Reset during a stall condition clears everything.
        feed(32'h300, 32'h01205020);
        cyc();
        feed(32'h304, 32'h200A0005);
        reset = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9;
        #1 chk("stall_during_reset", {31'h0, stall}, 32'h0);
        cyc();
        chk("rst_mid_stall_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_mid_stall_pc", id_pc, 32'h0);
        chk("rst_mid_stall_rs_data", id_rs_data, 32'h0);
        chk("rst_mid_stall_imm", id_imm, 32'h0);
        chk("rst_mid_stall_rd", {27'h0, id_rd}, 32'h0);
        chk("rst_mid_stall_funct", {26'h0, id_funct}, 32'h0);

        // First edge after reset loads normally; registers read back cleared.
        reset = 1'b0; ex_memread = 1'b0;
        feed(32'h400, 32'h01095020);
        push(32'h400, 32'h0, 32'h0, 32'h00005020, 5'd8, 5'd9, 5'd10, 6'h00, 6'h20);
        cyc();
        if_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
